// File: rtl/last_unique_4_tracker.sv
// last_unique_4_tracker
//   Keeps the four most recently seen distinct bytes of a free-running byte
//   stream as a move-to-front list. Slot 0 always holds the newest value.
//   Each slot has a 2-bit status: bit0 = occupied, bit1 = re-seen since
//   insertion.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset, clears every slot
//   data_in      byte sampled on every rising clk edge
//   out_0..3     slot values, 0 = most recent, 3 = least recent
//   out_valid_0..3  slot status {re-seen, occupied}
//
// Optional build macro:
//   LU4_ZERO_IGNORE_EN  when defined, data_in == 8'h00 is idle and all state holds.

module last_unique_4_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic [7:0] out_0,
  output logic [7:0] out_1,
  output logic [7:0] out_2,
  output logic [7:0] out_3,
  output logic [1:0] out_valid_0,
  output logic [1:0] out_valid_1,
  output logic [1:0] out_valid_2,
  output logic [1:0] out_valid_3
);

  logic [7:0] val_q [4];
  logic [7:0] val_d [4];
  logic [1:0] st_q  [4];
  logic [1:0] st_d  [4];
  logic [3:0] match;
  logic [3:1] shift;
  logic       hit;
  logic       idle;

  // Only occupied slots may match; slot values are distinct, so at most one hits.
  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      match[k] = st_q[k][0] && (val_q[k] == data_in);
    end
    hit = |match;
`ifdef LU4_ZERO_IGNORE_EN
    idle = (data_in == '0);
`else
    idle = 1'b0;
`endif
  end

  // Slot k takes slot k-1 when the hit lies at or below it (index >= k),
  // or on a miss. Slot 0 always ends up holding data_in: on a hit the
  // matching value equals data_in, so no mux on the hit index is needed.
  always_comb begin
    val_d = val_q;
    st_d  = st_q;
    shift = '0;
    if (!idle) begin
      for (int unsigned k = 1; k < 4; k++) begin
        shift[k] = !hit;
        for (int unsigned j = k; j < 4; j++) begin
          if (match[j]) shift[k] = 1'b1;
        end
        if (shift[k]) begin
          val_d[k] = val_q[k-1];
          st_d[k]  = st_q[k-1];
        end
      end
      val_d[0] = data_in;
      st_d[0]  = hit ? 2'b11 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < 4; k++) begin
        val_q[k] <= '0;
        st_q[k]  <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 4; k++) begin
        val_q[k] <= val_d[k];
        st_q[k]  <= st_d[k];
      end
    end
  end

  assign out_0       = val_q[0];
  assign out_1       = val_q[1];
  assign out_2       = val_q[2];
  assign out_3       = val_q[3];
  assign out_valid_0 = st_q[0];
  assign out_valid_1 = st_q[1];
  assign out_valid_2 = st_q[2];
  assign out_valid_3 = st_q[3];

endmodule

// File: tb/tb_last_unique_4_tracker.sv
// Testbench for last_unique_4_tracker: directed vector table, hand-written
// reset/zero sequences, and randomized traffic against a queue-based model.
module tb_last_unique_4_tracker;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic [7:0] out_0, out_1, out_2, out_3;
  logic [1:0] out_valid_0, out_valid_1, out_valid_2, out_valid_3;

  int checks;
  int errors;

  last_unique_4_tracker dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .out_0       (out_0),
    .out_1       (out_1),
    .out_2       (out_2),
    .out_3       (out_3),
    .out_valid_0 (out_valid_0),
    .out_valid_1 (out_valid_1),
    .out_valid_2 (out_valid_2),
    .out_valid_3 (out_valid_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: MRU list as a queue, front = newest.
  typedef struct packed {
    logic [7:0] v;
    logic       rs;
  } ent_t;
  ent_t mq[$];

  typedef struct packed {
    logic [7:0]  d;
    logic [31:0] ov;  // {out_0, out_1, out_2, out_3}
    logic [7:0]  vv;  // {valid_0, valid_1, valid_2, valid_3}
  } vec_t;

  function automatic logic [39:0] dut_vec();
    return {out_0, out_1, out_2, out_3, out_valid_0, out_valid_1, out_valid_2, out_valid_3};
  endfunction

  function automatic logic [39:0] model_vec();
    logic [7:0] v [4];
    logic [1:0] s [4];
    for (int i = 0; i < 4; i++) begin
      v[i] = 8'h00;
      s[i] = 2'b00;
    end
    for (int i = 0; i < mq.size(); i++) begin
      v[i] = mq[i].v;
      s[i] = {mq[i].rs, 1'b1};
    end
    return {v[0], v[1], v[2], v[3], s[0], s[1], s[2], s[3]};
  endfunction

  task automatic model_step(input logic [7:0] d);
    int idx;
`ifdef LU4_ZERO_IGNORE_EN
    if (d == 8'h00) return;
`endif
    idx = -1;
    foreach (mq[i]) if (mq[i].v == d) idx = i;
    if (idx >= 0) begin
      mq.delete(idx);
      mq.push_front('{v: d, rs: 1'b1});
    end else begin
      mq.push_front('{v: d, rs: 1'b0});
      if (mq.size() > 4) void'(mq.pop_back());
    end
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive away from the edge, sample 1 time unit after it.
  task automatic step(input logic [7:0] d);
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [13];

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    data_in = 8'h00;

    // Directed table: fill, evict, hit, repeat at head, re-entry, zeros.
    tbl[0]  = '{8'h01, 32'h01000000, {2'b01, 2'b00, 2'b00, 2'b00}};
    tbl[1]  = '{8'h09, 32'h09010000, {2'b01, 2'b01, 2'b00, 2'b00}};
    tbl[2]  = '{8'h02, 32'h02090100, {2'b01, 2'b01, 2'b01, 2'b00}};
    tbl[3]  = '{8'h03, 32'h03020901, {2'b01, 2'b01, 2'b01, 2'b01}};
    tbl[4]  = '{8'h04, 32'h04030209, {2'b01, 2'b01, 2'b01, 2'b01}};
    tbl[5]  = '{8'h03, 32'h03040209, {2'b11, 2'b01, 2'b01, 2'b01}};
    tbl[6]  = '{8'h07, 32'h07030402, {2'b01, 2'b11, 2'b01, 2'b01}};
    tbl[7]  = '{8'h07, 32'h07030402, {2'b11, 2'b11, 2'b01, 2'b01}};
    tbl[8]  = '{8'h01, 32'h01070304, {2'b01, 2'b11, 2'b11, 2'b01}};
    tbl[9]  = '{8'h01, 32'h01070304, {2'b11, 2'b11, 2'b11, 2'b01}};
`ifdef LU4_ZERO_IGNORE_EN
    tbl[10] = '{8'h00, 32'h01070304, {2'b11, 2'b11, 2'b11, 2'b01}};
    tbl[11] = '{8'h05, 32'h05010703, {2'b01, 2'b11, 2'b11, 2'b11}};
    tbl[12] = '{8'h00, 32'h05010703, {2'b01, 2'b11, 2'b11, 2'b11}};
`else
    tbl[10] = '{8'h00, 32'h00010703, {2'b01, 2'b11, 2'b11, 2'b11}};
    tbl[11] = '{8'h05, 32'h05000107, {2'b01, 2'b01, 2'b11, 2'b11}};
    tbl[12] = '{8'h00, 32'h00050107, {2'b11, 2'b01, 2'b11, 2'b11}};
`endif

    #1;
    check("reset_initial", dut_vec(), 40'h0);
    @(posedge clk);
    #3 rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].d);
      check($sformatf("table[%0d]", i), dut_vec(), {tbl[i].ov, tbl[i].vv});
    end

    // Asynchronous reset mid-clock with slots full: clears before the next edge.
    #2 rst = 1'b1;
    #1 check("async_reset_immediate", dut_vec(), 40'h0);
    @(posedge clk);
    #1 check("reset_held_over_edge", dut_vec(), 40'h0);
    #2 rst = 1'b0;
    mq.delete();

    // Zero into an empty list: empty slots hold 0 but must never match.
    step(8'h00);
    model_step(8'h00);
`ifdef LU4_ZERO_IGNORE_EN
    check("zero_after_reset", dut_vec(), 40'h0);
`else
    check("zero_after_reset", dut_vec(), {32'h00000000, 2'b01, 2'b00, 2'b00, 2'b00});
`endif
    check("zero_after_reset_model", dut_vec(), model_vec());

    // Randomized traffic over a small alphabet for frequent hits, with
    // occasional asynchronous resets.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] d;
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        mq.delete();
        #1 check("rand_reset", dut_vec(), model_vec());
        #2 rst = 1'b0;
      end
      d = 8'($urandom_range(0, 6));
      step(d);
      model_step(d);
      check($sformatf("rand[%0d] d=%h", n, d), dut_vec(), model_vec());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
